// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - UART word request responder: OUT word to TX bytes, RX byte FIFO to IN words
module uart_io_ctrl #(
    parameter int RX_DEPTH = 16,
    parameter int RX_AW    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_wenable,
    input  logic [1:0]        uart_wsz,
    input  logic [31:0]       uart_wd,
    output logic              uart_wdone,
    input  logic              uart_renable,
    input  logic [1:0]        uart_rsz,
    output logic [31:0]       uart_rd,
    output logic              uart_rdone,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_overrun,
    output logic [RX_AW:0]    rx_count
);

    typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_state_t;
    typedef enum logic {R_IDLE, R_COLLECT} rx_state_t;

    tx_state_t   t_state, t_next;
    logic [31:0] shreg;
    logic [1:0]  t_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) t_state <= T_IDLE;
        else       t_state <= t_next;
    end

    always_comb begin
        t_next   = t_state;
        tx_start = 1'b0;
        case (t_state)
            T_IDLE: if (uart_wenable) t_next = T_SEND;
            T_SEND: if (!tx_busy) begin
                tx_start = 1'b1;
                t_next   = (t_cnt == 2'd0) ? T_IDLE : T_GAP;
            end
            // one idle cycle so the transmitter's busy flag is visible before the next start
            T_GAP:   t_next = T_SEND;
            default: t_next = T_IDLE;
        endcase
    end

    assign tx_data = tx_start ? shreg[7:0] : 8'h00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg      <= '0;
            t_cnt      <= '0;
            uart_wdone <= 1'b0;
        end else begin
            uart_wdone <= tx_start && (t_cnt == 2'd0);
            if (t_state == T_IDLE && uart_wenable) begin
                shreg <= uart_wd;
                t_cnt <= uart_wsz;
            end else if (tx_start && t_cnt != 2'd0) begin
                shreg <= shreg >> 8;
                t_cnt <= t_cnt - 2'd1;
            end
        end
    end

    logic [7:0]       mem [RX_DEPTH];
    logic [RX_AW-1:0] wptr, rptr;
    logic             fifo_empty, fifo_full, push, pop;
    logic [7:0]       head;

    rx_state_t   r_state, r_next;
    logic [1:0]  r_idx, r_sz;
    logic [31:0] acc, acc_merged, rd_q;

    assign fifo_empty = (rx_count == '0);
    assign fifo_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign pop        = (r_state == R_COLLECT) && !fifo_empty;
    // a full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push       = rx_valid && (!fifo_full || pop);
    assign head       = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      rx_count <= rx_count + 1'b1;
            else if (pop && !push) rx_count <= rx_count - 1'b1;
            if (rx_valid && !push) rx_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // the completing byte is merged combinationally so rdone coincides with the last pop
    always_comb begin
        acc_merged              = acc;
        acc_merged[8*r_idx +: 8] = head;
        r_next                  = r_state;
        uart_rdone              = 1'b0;
        case (r_state)
            R_IDLE:    if (uart_renable) r_next = R_COLLECT;
            R_COLLECT: if (pop && r_idx == r_sz) begin
                uart_rdone = 1'b1;
                r_next     = R_IDLE;
            end
            default:   r_next = R_IDLE;
        endcase
    end

    assign uart_rd = uart_rdone ? acc_merged : rd_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc   <= '0;
            r_idx <= '0;
            r_sz  <= '0;
            rd_q  <= '0;
        end else begin
            if (r_state == R_IDLE && uart_renable) begin
                acc   <= '0;
                r_idx <= '0;
                r_sz  <= uart_rsz;
            end else if (pop) begin
                acc   <= acc_merged;
                r_idx <= r_idx + 2'd1;
            end
            if (uart_rdone) rd_q <= acc_merged;
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb/tb_uart_io_ctrl.sv - scoreboard bench for uart_io_ctrl
module tb_uart_io_ctrl;
    localparam int RX_DEPTH = 16;
    localparam int RX_AW    = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              uart_wenable, uart_renable, rx_valid, tx_busy;
    logic [1:0]        uart_wsz, uart_rsz;
    logic [31:0]       uart_wd, uart_rd;
    logic              uart_wdone, uart_rdone, tx_start, rx_overrun;
    logic [7:0]        tx_data, rx_data;
    logic [RX_AW:0]    rx_count;

    uart_io_ctrl #(.RX_DEPTH(RX_DEPTH), .RX_AW(RX_AW)) dut (
        .clk(clk), .rstn(rstn),
        .uart_wenable(uart_wenable), .uart_wsz(uart_wsz), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
        .uart_renable(uart_renable), .uart_rsz(uart_rsz), .uart_rd(uart_rd), .uart_rdone(uart_rdone),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_overrun(rx_overrun), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, tx_starts = 0, wdones = 0, rdones = 0;
    int last_start_cyc = 0, wdone_cyc = 0;
    int busy_cnt;
    logic [7:0]  tx_exp[$];
    logic [31:0] rd_exp[$];
    logic [7:0]  model[$];
    logic        exp_ovr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // byte transmitter model: busy for 10 cycles after each accepted start
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start && !tx_busy) begin
            tx_busy  <= 1'b1;
            busy_cnt <= 10;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (tx_start) begin
                check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
                if (tx_exp.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
                else                    check("tx_data", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
                tx_starts++;
                last_start_cyc = cyc;
            end
            if (uart_wdone) begin
                wdones++;
                wdone_cyc = cyc;
            end
            if (uart_rdone) begin
                if (rd_exp.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else                    check("uart_rd", uart_rd, rd_exp.pop_front());
                rdones++;
            end
        end
    end

    task automatic wait_wdone(input int target, input string tag);
        for (int i = 0; i < 400 && wdones < target; i++) @(posedge clk);
        #1 check(tag, wdones, target);
    endtask

    task automatic wait_rdone(input int target, input string tag);
        for (int i = 0; i < 400 && rdones < target; i++) @(posedge clk);
        #1 check(tag, rdones, target);
    endtask

    task automatic do_out(input logic [1:0] sz, input logic [31:0] d);
        @(posedge clk); #1;
        uart_wenable = 1'b1; uart_wsz = sz; uart_wd = d;
        for (int i = 0; i <= int'(sz); i++) tx_exp.push_back(d[8*i +: 8]);
        @(posedge clk); #1;
        uart_wenable = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        if (model.size() < RX_DEPTH) model.push_back(b);
        else                         exp_ovr = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_in(input logic [1:0] sz);
        logic [31:0] w = '0;
        int r0 = rdones;
        for (int i = 0; i <= int'(sz); i++) w[8*i +: 8] = model.pop_front();
        rd_exp.push_back(w);
        @(posedge clk); #1;
        uart_renable = 1'b1; uart_rsz = sz;
        @(posedge clk); #1;
        uart_renable = 1'b0;
        wait_rdone(r0 + 1, "in_done");
    endtask

    initial begin
        int s0, w0, r0;
        logic [31:0] w;
        rstn = 1'b0;
        uart_wenable = 0; uart_renable = 0; uart_wsz = 0; uart_rsz = 0; uart_wd = 0;
        rx_valid = 0; rx_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_wdone", {31'd0, uart_wdone}, 0);
        check("rst_rdone", {31'd0, uart_rdone}, 0);
        check("rst_rd", uart_rd, 0);
        check("rst_count", {27'd0, rx_count}, 0);
        check("rst_overrun", {31'd0, rx_overrun}, 0);
        rstn = 1'b1;

        // 4-byte OUT against a slow transmitter
        w0 = wdones; s0 = tx_starts;
        do_out(2'b11, 32'hDEADBEEF);
        wait_wdone(w0 + 1, "out4_done");
        check("out4_starts", tx_starts - s0, 4);
        check("out4_wdone_gap", wdone_cyc - last_start_cyc, 1);
        repeat (20) @(posedge clk);
        #1 check("out4_single_wdone", wdones, w0 + 1);

        // reset in the middle of a 4-byte OUT
        w0 = wdones; s0 = tx_starts;
        do_out(2'b11, 32'hCAFEF00D);
        for (int i = 0; i < 200 && tx_starts < s0 + 2; i++) @(posedge clk);
        check("mid_two_sent", tx_starts - s0, 2);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        tx_exp.delete();
        #1;
        check("mid_rst_tx_start", {31'd0, tx_start}, 0);
        check("mid_rst_wdone", {31'd0, uart_wdone}, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1 check("mid_no_wdone", wdones, w0);
        check("mid_no_more_starts", tx_starts - s0, 2);

        // minimum-latency 1-byte OUT after reset
        @(posedge clk); #1;
        uart_wenable = 1'b1; uart_wsz = 2'b00; uart_wd = 32'h0000005A;
        tx_exp.push_back(8'h5A);
        @(posedge clk); #1;
        uart_wenable = 1'b0;
        check("lat_tx_start", {31'd0, tx_start}, 1);
        @(posedge clk); #1;
        check("lat_wdone", {31'd0, uart_wdone}, 1);
        @(posedge clk); #1;
        check("lat_wdone_pulse", {31'd0, uart_wdone}, 0);

        // 2-byte IN from a pre-loaded FIFO
        push_rx(8'h34); push_rx(8'h12); push_rx(8'h99);
        check("pre_count", {27'd0, rx_count}, 3);
        w = '0;
        for (int i = 0; i < 2; i++) w[8*i +: 8] = model.pop_front();
        rd_exp.push_back(w);
        @(posedge clk); #1;
        uart_renable = 1'b1; uart_rsz = 2'b01;
        @(posedge clk); #1;
        uart_renable = 1'b0;
        check("in2_not_yet", {31'd0, uart_rdone}, 0);
        @(posedge clk); #1;
        check("in2_rdone", {31'd0, uart_rdone}, 1);
        check("in2_rd", uart_rd, 32'h00001234);
        @(posedge clk); #1;
        check("in2_rdone_pulse", {31'd0, uart_rdone}, 0);
        check("in2_rd_held", uart_rd, 32'h00001234);
        check("in2_count_after", {27'd0, rx_count}, model.size());
        do_in(2'b00);

        // 4-byte IN waiting on an empty FIFO
        rd_exp.push_back(32'h04030201);
        @(posedge clk); #1;
        uart_renable = 1'b1; uart_rsz = 2'b11;
        @(posedge clk); #1;
        uart_renable = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            repeat (4) @(posedge clk);
            #1 rx_valid = 1'b1; rx_data = 8'(b);
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (b == 4) begin
                check("in4_rdone", {31'd0, uart_rdone}, 1);
                check("in4_rd", uart_rd, 32'h04030201);
            end else begin
                check("in4_early", {31'd0, uart_rdone}, 0);
            end
        end
        @(posedge clk); #1;
        check("in4_count", {27'd0, rx_count}, 0);

        // overrun, wrap-around drain, simultaneous push/pop while full
        for (int i = 0; i < 17; i++) push_rx(8'h10 + 8'(i));
        check("ovr_count", {27'd0, rx_count}, RX_DEPTH);
        check("ovr_flag", {31'd0, rx_overrun}, {31'd0, exp_ovr});
        for (int i = 0; i < 4; i++) do_in(2'b11);
        check("ovr_drained", {27'd0, rx_count}, 0);
        for (int i = 0; i < 16; i++) push_rx(8'h60 + 8'(i));
        check("refill_count", {27'd0, rx_count}, RX_DEPTH);
        rd_exp.push_back({24'd0, model.pop_front()});
        @(posedge clk); #1;
        uart_renable = 1'b1; uart_rsz = 2'b00;
        @(posedge clk); #1;
        uart_renable = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hAA;
        model.push_back(8'hAA);
        check("full_pp_rdone", {31'd0, uart_rdone}, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("full_pp_count", {27'd0, rx_count}, RX_DEPTH);
        check("full_pp_overrun", {31'd0, rx_overrun}, 1);
        for (int i = 0; i < 4; i++) do_in(2'b11);
        check("final_drain", {27'd0, rx_count}, 0);

        // concurrent 1-byte OUT and 1-byte IN
        push_rx(8'h41);
        w0 = wdones; r0 = rdones;
        @(posedge clk); #1;
        uart_wenable = 1'b1; uart_wsz = 2'b00; uart_wd = 32'h00000077;
        tx_exp.push_back(8'h77);
        uart_renable = 1'b1; uart_rsz = 2'b00;
        rd_exp.push_back({24'd0, model.pop_front()});
        @(posedge clk); #1;
        uart_wenable = 1'b0; uart_renable = 1'b0;
        check("conc_tx_start", {31'd0, tx_start}, 1);
        check("conc_rdone", {31'd0, uart_rdone}, 1);
        check("conc_rd", uart_rd, 32'h00000041);
        @(posedge clk); #1;
        check("conc_wdone", {31'd0, uart_wdone}, 1);
        repeat (5) @(posedge clk);
        #1 check("conc_wdone_count", wdones, w0 + 1);
        check("conc_rdone_count", rdones, r0 + 1);

        check("tx_exp_empty", tx_exp.size(), 0);
        check("rd_exp_empty", rd_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
